touch_point_sequencer: RTL and testbench

//  Sequences the point-sound store. In record mode, walks the user through

---
 rtl/touch_point_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_touch_point_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/touch_point_sequencer.sv
// Touch point sequencer: 4-point record/calibrate FSM plus
// per-frame hit debouncing into note events for playback.
module touch_point_sequencer #(
   parameter int          TIMEOUT_FRAMES  = 8,
   parameter int          DEBOUNCE_FRAMES = 2,
   parameter logic [23:0] NOTE_HOLD       = 24'd4_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_record_key,
   input  logic       i_confirm,
   input  logic       i_frame_start,
   input  logic       i_spot_valid,
   input  logic [9:0] i_spot_x,
   input  logic [9:0] i_spot_y,
   input  logic [2:0] i_sound_num,
   output logic       o_state,
   output logic [2:0] o_mask,
   output logic       o_detect_finished,
   output logic [9:0] o_x,
   output logic [9:0] o_y,
   output logic [2:0] o_point_idx,
   output logic       o_error,
   output logic [2:0] o_note,
   output logic       o_note_start,
   output logic       o_note_active
);

   localparam int TW = $clog2(TIMEOUT_FRAMES + 1);
   localparam int DW = $clog2(DEBOUNCE_FRAMES + 1);
   localparam logic [TW-1:0] TMO = TW'(TIMEOUT_FRAMES);
   localparam logic [DW-1:0] DEB = DW'(DEBOUNCE_FRAMES);

   typedef enum logic [2:0] {
      S_PLAY, S_ARM, S_WAIT, S_SAMPLE, S_COMMIT
   } state_t;

   state_t          state_q;
   logic [2:0]      idx_q;
   logic [TW-1:0]   tcnt_q;
   logic [TW-1:0]   tcnt_d;
   logic            spot_q;
   logic [9:0]      sx_q, sy_q;
   logic            state_o_q, done_q, err_q;
   logic [2:0]      mask_q;
   logic [9:0]      x_q, y_q;

   assign tcnt_d = tcnt_q + TW'(1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_PLAY;
         idx_q     <= '0;
         tcnt_q    <= '0;
         spot_q    <= 1'b0;
         sx_q      <= '0;
         sy_q      <= '0;
         state_o_q <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         mask_q    <= '0;
         x_q       <= '0;
         y_q       <= '0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         mask_q <= '0;
         if (i_record_key) begin
            state_q   <= S_ARM;
            idx_q     <= 3'd1;
            state_o_q <= 1'b1;
         end else begin
            unique case (state_q)
               S_PLAY: begin
               end
               S_ARM: begin
                  if (i_confirm) state_q <= S_WAIT;
               end
               S_WAIT: begin
                  if (i_frame_start) begin
                     state_q <= S_SAMPLE;
                     spot_q  <= 1'b0;
                     tcnt_q  <= '0;
                  end
               end
               S_SAMPLE: begin
                  if (i_spot_valid) begin
                     sx_q   <= i_spot_x;
                     sy_q   <= i_spot_y;
                     spot_q <= 1'b1;
                  end
                  // a spot on the frame_start cycle still belongs to the old frame
                  if (i_frame_start) begin
                     if (spot_q || i_spot_valid) begin
                        state_q <= S_COMMIT;
                        done_q  <= 1'b1;
                        mask_q  <= idx_q;
                        x_q     <= i_spot_valid ? i_spot_x : sx_q;
                        y_q     <= i_spot_valid ? i_spot_y : sy_q;
                     end else if (tcnt_d == TMO) begin
                        err_q   <= 1'b1;
                        state_q <= S_ARM;
                     end else begin
                        tcnt_q <= tcnt_d;
                     end
                  end
               end
               S_COMMIT: begin
                  if (idx_q == 3'd4) begin
                     state_q   <= S_PLAY;
                     idx_q     <= '0;
                     state_o_q <= 1'b0;
                  end else begin
                     state_q <= S_ARM;
                     idx_q   <= idx_q + 3'd1;
                  end
               end
               default: state_q <= S_PLAY;
            endcase
         end
      end
   end

   logic [3:0]          hit_q, hit_now, fire;
   logic [3:0][DW-1:0]  cnt_q, cnt_d;
   logic [2:0]          note_q, note_d;
   logic                start_q, active_q;
   logic [23:0]         hold_q;

   always_comb begin
      case (i_sound_num)
         3'd1:    hit_now = 4'b0001;
         3'd2:    hit_now = 4'b0010;
         3'd3:    hit_now = 4'b0100;
         3'd4:    hit_now = 4'b1000;
         default: hit_now = 4'b0000;
      endcase
   end

   always_comb begin
      cnt_d = cnt_q;
      fire  = '0;
      for (int k = 0; k < 4; k++) begin
         if (!hit_q[k])          cnt_d[k] = '0;
         else if (cnt_q[k] != DEB) cnt_d[k] = cnt_q[k] + DW'(1);
         fire[k] = (cnt_d[k] == DEB) && (cnt_q[k] != DEB);
      end
   end

   always_comb begin
      note_d = '0;
      priority case (1'b1)
         fire[0]: note_d = 3'd1;
         fire[1]: note_d = 3'd2;
         fire[2]: note_d = 3'd3;
         fire[3]: note_d = 3'd4;
         default: note_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hit_q    <= '0;
         cnt_q    <= '0;
         note_q   <= '0;
         start_q  <= 1'b0;
         active_q <= 1'b0;
         hold_q   <= '0;
      end else begin
         start_q <= 1'b0;
         if (hold_q != '0) begin
            hold_q   <= hold_q - 24'd1;
            active_q <= (hold_q != 24'd1);
         end
         if (state_q != S_PLAY || i_record_key) begin
            hit_q <= '0;
            cnt_q <= '0;
         end else if (i_frame_start) begin
            hit_q <= hit_now;
            cnt_q <= cnt_d;
            if (|fire) begin
               note_q   <= note_d;
               start_q  <= 1'b1;
               active_q <= 1'b1;
               hold_q   <= NOTE_HOLD;
            end
         end else begin
            hit_q <= hit_q | hit_now;
         end
      end
   end

   assign o_state           = state_o_q;
   assign o_mask            = mask_q;
   assign o_detect_finished = done_q;
   assign o_x               = x_q;
   assign o_y               = y_q;
   assign o_point_idx       = idx_q;
   assign o_error           = err_q;
   assign o_note            = note_q;
   assign o_note_start      = start_q;
   assign o_note_active     = active_q;

endmodule

// File: tb/tb_touch_point_sequencer.sv
// Scoreboard bench: stimulus pushes expected commit/error/note
// events; a negedge monitor pops and compares them.
module tb_touch_point_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       i_record_key = 1'b0;
   logic       i_confirm = 1'b0;
   logic       i_frame_start = 1'b0;
   logic       i_spot_valid = 1'b0;
   logic [9:0] i_spot_x = '0;
   logic [9:0] i_spot_y = '0;
   logic [2:0] i_sound_num = '0;
   logic       o_state, o_detect_finished, o_error;
   logic       o_note_start, o_note_active;
   logic [2:0] o_mask, o_point_idx, o_note;
   logic [9:0] o_x, o_y;

   always #5 clk = ~clk;

   touch_point_sequencer #(.NOTE_HOLD(24'd30)) dut (
      .clk(clk), .rst(rst),
      .i_record_key(i_record_key), .i_confirm(i_confirm),
      .i_frame_start(i_frame_start), .i_spot_valid(i_spot_valid),
      .i_spot_x(i_spot_x), .i_spot_y(i_spot_y),
      .i_sound_num(i_sound_num),
      .o_state(o_state), .o_mask(o_mask),
      .o_detect_finished(o_detect_finished),
      .o_x(o_x), .o_y(o_y), .o_point_idx(o_point_idx),
      .o_error(o_error), .o_note(o_note),
      .o_note_start(o_note_start), .o_note_active(o_note_active)
   );

   typedef struct packed {
      logic [1:0] kind;
      logic [2:0] m;
      logic [9:0] x;
      logic [9:0] y;
   } ev_t;

   localparam logic [1:0] K_COMMIT = 2'd0;
   localparam logic [1:0] K_ERR    = 2'd1;
   localparam logic [1:0] K_NOTE   = 2'd2;

   ev_t q[$];
   int  n_cmp = 0;
   int  n_bad = 0;

   task automatic check(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      ev_t a, e;
      if (rst && (o_detect_finished || o_error || o_note_start)) begin
         a = '0;
         if (o_detect_finished) begin
            a.kind = K_COMMIT; a.m = o_mask; a.x = o_x; a.y = o_y;
         end else if (o_error) begin
            a.kind = K_ERR;
         end else begin
            a.kind = K_NOTE; a.m = o_note;
         end
         n_cmp++;
         if (q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_event: got %h expected none", a);
         end else begin
            e = q.pop_front();
            if (a != e) begin
               n_bad++;
               $display("FAIL event: got %h expected %h", a, e);
            end
         end
      end
   end

   function automatic ev_t mk(input logic [1:0] k, input logic [2:0] m,
                              input logic [9:0] x, input logic [9:0] y);
      ev_t e;
      e.kind = k; e.m = m; e.x = x; e.y = y;
      return e;
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic fs();
      i_frame_start = 1'b1; cyc(1); i_frame_start = 1'b0;
   endtask

   task automatic rec();
      i_record_key = 1'b1; cyc(1); i_record_key = 1'b0;
   endtask

   task automatic conf();
      i_confirm = 1'b1; cyc(1); i_confirm = 1'b0;
   endtask

   task automatic spot(input logic [9:0] x, input logic [9:0] y);
      i_spot_valid = 1'b1; i_spot_x = x; i_spot_y = y;
      cyc(1);
      i_spot_valid = 1'b0;
   endtask

   task automatic capture(input logic [9:0] x, input logic [9:0] y,
                          input logic [2:0] m);
      conf(); cyc(2); fs(); cyc(2);
      spot(x + 10'd5, y + 10'd5);
      spot(x, y);
      cyc(1);
      q.push_back(mk(K_COMMIT, m, x, y));
      fs(); cyc(1);
   endtask

   task automatic play_frame(input logic [2:0] s1, input logic [2:0] s2);
      cyc(1);
      i_sound_num = s1; cyc(2);
      i_sound_num = s2; cyc(2);
      i_sound_num = '0; cyc(1);
      fs();
   endtask

   initial begin
      cyc(3);
      rst = 1'b1;
      cyc(1);
      check("rst_state", o_state, 0);
      check("rst_idx", o_point_idx, 0);
      check("rst_note", o_note, 0);
      check("rst_active", o_note_active, 0);
      check("rst_xy", {o_x, o_y}, 0);

      rec();
      check("rec_state", o_state, 1);
      check("rec_idx", o_point_idx, 1);
      capture(10'd100, 10'd50, 3'd1);
      check("idx_after_1", o_point_idx, 2);

      rec();
      check("restart_idx", o_point_idx, 1);
      for (int i = 1; i <= 4; i++)
         capture(10'(i * 10), 10'(i * 10), 3'(i));
      check("run_state", o_state, 0);
      check("run_idx", o_point_idx, 0);

      rec(); conf(); cyc(1); fs();
      for (int i = 1; i <= 8; i++) begin
         cyc(2);
         if (i == 8) q.push_back(mk(K_ERR, 3'd0, 10'd0, 10'd0));
         fs();
      end
      cyc(1);
      check("tmo_idx", o_point_idx, 1);
      check("tmo_state", o_state, 1);

      conf(); cyc(1); fs(); cyc(2);
      q.push_back(mk(K_COMMIT, 3'd1, 10'd7, 10'd9));
      i_spot_valid = 1'b1; i_spot_x = 10'd7; i_spot_y = 10'd9;
      i_frame_start = 1'b1;
      cyc(1);
      i_spot_valid = 1'b0; i_frame_start = 1'b0;
      cyc(1);
      check("coinc_idx", o_point_idx, 2);

      capture(10'd222, 10'd333, 3'd2);
      check("abort_pre_idx", o_point_idx, 3);
      conf(); cyc(1); fs(); cyc(1);
      spot(10'd55, 10'd66);
      rec();
      check("abort_idx", o_point_idx, 1);
      cyc(2); fs(); cyc(2);
      check("abort_hold_idx", o_point_idx, 1);

      for (int i = 1; i <= 4; i++)
         capture(10'(i * 3), 10'(i * 7), 3'(i));
      check("play_state", o_state, 0);

      play_frame(3'd2, 3'd2);
      q.push_back(mk(K_NOTE, 3'd2, 10'd0, 10'd0));
      play_frame(3'd2, 3'd2);
      check("note2", o_note, 2);
      check("note2_active", o_note_active, 1);
      for (int i = 0; i < 5; i++) play_frame(3'd2, 3'd2);
      play_frame(3'd0, 3'd0);

      play_frame(3'd3, 3'd1);
      q.push_back(mk(K_NOTE, 3'd1, 10'd0, 10'd0));
      play_frame(3'd3, 3'd1);
      check("note1", o_note, 1);

      play_frame(3'd0, 3'd0);
      i_sound_num = 3'd4; i_frame_start = 1'b1;
      cyc(1);
      i_sound_num = '0; i_frame_start = 1'b0;
      cyc(3); fs();
      q.push_back(mk(K_NOTE, 3'd4, 10'd0, 10'd0));
      play_frame(3'd4, 3'd4);
      check("note4", o_note, 4);
      cyc(29);
      check("hold_last", o_note_active, 1);
      cyc(1);
      check("hold_end", o_note_active, 0);

      play_frame(3'd0, 3'd0);
      play_frame(3'd4, 3'd4);
      q.push_back(mk(K_NOTE, 3'd4, 10'd0, 10'd0));
      play_frame(3'd4, 3'd4);
      rec(); conf(); cyc(1); fs();
      spot(10'd1, 10'd2);
      cyc(1); fs();
      check("pre_rst_done", o_detect_finished, 1);
      check("pre_rst_active", o_note_active, 1);
      rst = 1'b0;
      #1;
      check("arst_done", o_detect_finished, 0);
      check("arst_mask", o_mask, 0);
      check("arst_xy", {o_x, o_y}, 0);
      check("arst_state", o_state, 0);
      check("arst_idx", o_point_idx, 0);
      check("arst_note", {o_note, o_note_start, o_note_active, o_error}, 0);
      cyc(2);
      rst = 1'b1;
      cyc(3);
      check("post_rst_state", o_state, 0);
      check("queue_empty", q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
